// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - write-back requester bus and register-file write port
interface wb_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 3
);
  // Requester side: one valid/ready pair per producer, flattened addr/data
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [5*NUM_REQ-1:0]          req_addr;
  logic [DATA_WIDTH*NUM_REQ-1:0] req_data;

  // Register-file single write port
  logic                          rf_wr_en;
  logic [4:0]                    rf_wr_addr;
  logic [DATA_WIDTH-1:0]         rf_wr_data;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, rf_wr_en, rf_wr_addr, rf_wr_data
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, rf_wr_en, rf_wr_addr, rf_wr_data
  );
endinterface

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin write-back arbiter with register scoreboard (optional: WB_SCOREBOARD_EN)
module wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_arbiter_if.slave wb,
  input  logic        iss_valid,
  input  logic [4:0]  iss_addr,
  output logic        iss_stall,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        hazard_rs1,
  output logic        hazard_rs2,
  output logic [31:0] busy
);

  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      grant_idx;
  logic [PTR_W-1:0]      next_ptr;
  logic [PTR_W:0]        cand;
  logic                  grant_any;
  logic [NUM_REQ-1:0]    grant;
  logic [4:0]            sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  // Round-robin search starting at rr_ptr; first valid requester wins
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_REQ)) begin
        cand = cand - (PTR_W+1)'(NUM_REQ);
      end
      if (!grant_any && wb.req_valid[cand[PTR_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[PTR_W-1:0];
      end
    end
    grant = grant_any ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx) : '0;
  end

  // Steer the granted requester's destination and data to the output stage
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        sel_addr = wb.req_addr[5*k +: 5];
        sel_data = wb.req_data[DATA_WIDTH*k +: DATA_WIDTH];
      end
    end
  end

  assign next_ptr     = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + PTR_W'(1);
  assign wb.req_ready = grant;

  // Registered write port; x0 results are consumed but never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr        <= '0;
      wb.rf_wr_en   <= 1'b0;
      wb.rf_wr_addr <= '0;
      wb.rf_wr_data <= '0;
    end else if (grant_any) begin
      rr_ptr        <= next_ptr;
      wb.rf_wr_en   <= (sel_addr != 5'd0);
      wb.rf_wr_addr <= sel_addr;
      wb.rf_wr_data <= sel_data;
    end else begin
      wb.rf_wr_en   <= 1'b0;
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [31:0] busy_q;
  logic        sb_set;

  assign sb_set = iss_valid && !iss_stall && (iss_addr != 5'd0);

  // Pending-write vector: clear on commit, set on issue; set is applied last so it wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      if (wb.rf_wr_en) begin
        busy_q[wb.rf_wr_addr] <= 1'b0;
      end
      if (sb_set) begin
        busy_q[iss_addr] <= 1'b1;
      end
    end
  end

  assign busy       = busy_q;
  assign iss_stall  = iss_valid && busy_q[iss_addr];
  assign hazard_rs1 = busy_q[rs1_addr];
  assign hazard_rs2 = busy_q[rs2_addr];
`else
  logic unused_sb;

  assign unused_sb  = ^{iss_valid, iss_addr, rs1_addr, rs2_addr};
  assign busy       = '0;
  assign iss_stall  = 1'b0;
  assign hazard_rs1 = 1'b0;
  assign hazard_rs2 = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter
module tb_wb_arbiter;
  localparam int DW = 32;
  localparam int NR = 3;
`ifdef WB_SCOREBOARD_EN
  localparam bit SB_EN = 1'b1;
`else
  localparam bit SB_EN = 1'b0;
`endif

  typedef struct {
    bit          rst;
    logic [2:0]  valid;
    logic [14:0] addr;
    logic [95:0] data;
    logic [2:0]  exp_ready;
  } vec_t;

  typedef struct packed {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } rf_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic        iss_stall;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        hazard_rs1;
  logic        hazard_rs2;
  logic [31:0] busy;

  always #5 clk = ~clk;

  wb_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) wb ();

  wb_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wb(wb),
    .iss_valid(iss_valid),
    .iss_addr(iss_addr),
    .iss_stall(iss_stall),
    .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr),
    .hazard_rs1(hazard_rs1),
    .hazard_rs2(hazard_rs2),
    .busy(busy)
  );

  int   n_pass = 0;
  int   n_tot  = 0;
  vec_t vecs[$];
  rf_t  sb_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input bit r, input logic [2:0] v,
                              input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                              input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                              input logic [2:0] e);
    vec_t t;
    t.rst       = r;
    t.valid     = v;
    t.addr      = {a2, a1, a0};
    t.data      = {d2, d1, d0};
    t.exp_ready = e;
    return t;
  endfunction

  task automatic clear_inputs();
    wb.req_valid = '0;
    wb.req_addr  = '0;
    wb.req_data  = '0;
    iss_valid    = 1'b0;
    iss_addr     = '0;
    rs1_addr     = '0;
    rs2_addr     = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rf_t         e;
    rf_t         nx;
    logic [4:0]  last_addr;
    logic [31:0] last_data;

    clear_inputs();
    last_addr = '0;
    last_data = '0;

    vecs.push_back(mk(1, 3'b001, 5,  0,  0, 32'hDEADBEEF, 0, 0, 3'b001));
    vecs.push_back(mk(0, 3'b000, 0,  0,  0, 0, 0, 0, 3'b000));
    vecs.push_back(mk(0, 3'b000, 0,  0,  0, 0, 0, 0, 3'b000));
    vecs.push_back(mk(1, 3'b111, 1,  2,  3, 32'hA1, 32'hA2, 32'hA3, 3'b001));
    vecs.push_back(mk(0, 3'b111, 1,  2,  3, 32'hA1, 32'hA2, 32'hA3, 3'b010));
    vecs.push_back(mk(0, 3'b111, 1,  2,  3, 32'hA1, 32'hA2, 32'hA3, 3'b100));
    vecs.push_back(mk(0, 3'b111, 1,  2,  3, 32'hA1, 32'hA2, 32'hA3, 3'b001));
    vecs.push_back(mk(0, 3'b111, 1,  2,  3, 32'hA1, 32'hA2, 32'hA3, 3'b010));
    vecs.push_back(mk(0, 3'b111, 1,  2,  3, 32'hA1, 32'hA2, 32'hA3, 3'b100));
    vecs.push_back(mk(0, 3'b000, 0,  0,  0, 0, 0, 0, 3'b000));
    vecs.push_back(mk(0, 3'b001, 0,  0,  0, 32'h1234, 0, 0, 3'b001));
    vecs.push_back(mk(0, 3'b000, 0,  0,  0, 0, 0, 0, 3'b000));
    vecs.push_back(mk(0, 3'b110, 0,  4,  6, 0, 32'hB4, 32'hB6, 3'b010));
    vecs.push_back(mk(0, 3'b100, 0,  0,  6, 0, 0, 32'hB6, 3'b100));
    vecs.push_back(mk(0, 3'b011, 8, 10,  0, 32'hC8, 32'hCA, 0, 3'b001));
    vecs.push_back(mk(0, 3'b010, 0, 10,  0, 0, 32'hCA, 0, 3'b010));
    vecs.push_back(mk(0, 3'b101, 11, 0, 12, 32'hDB, 0, 32'hDC, 3'b100));
    vecs.push_back(mk(0, 3'b001, 11, 0,  0, 32'hDB, 0, 0, 3'b001));
    vecs.push_back(mk(0, 3'b101, 13, 0, 14, 32'hED, 0, 32'hEE, 3'b100));
    vecs.push_back(mk(0, 3'b001, 13, 0,  0, 32'hED, 0, 0, 3'b001));
    vecs.push_back(mk(0, 3'b000, 0,  0,  0, 0, 0, 0, 3'b000));

    foreach (vecs[i]) begin
      if (vecs[i].rst) begin
        do_reset();
        sb_q.delete();
        sb_q.push_back('0);
        last_addr = '0;
        last_data = '0;
      end
      wb.req_valid = vecs[i].valid;
      wb.req_addr  = vecs[i].addr;
      wb.req_data  = vecs[i].data;
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), wb.req_ready, vecs[i].exp_ready);
      if (sb_q.size() == 0) begin
        n_tot++;
        $display("FAIL v%0d_sb_empty: actual empty required entry", i);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("v%0d_wr_en", i),   wb.rf_wr_en,   e.en);
        chk($sformatf("v%0d_wr_addr", i), wb.rf_wr_addr, e.addr);
        chk($sformatf("v%0d_wr_data", i), wb.rf_wr_data, e.data);
      end
      nx.en   = 1'b0;
      nx.addr = last_addr;
      nx.data = last_data;
      for (int k = 0; k < NR; k++) begin
        if (vecs[i].exp_ready[k]) begin
          nx.addr = vecs[i].addr[5*k +: 5];
          nx.data = vecs[i].data[32*k +: 32];
          nx.en   = (nx.addr != 5'd0);
        end
      end
      last_addr = nx.addr;
      last_data = nx.data;
      sb_q.push_back(nx);
      @(posedge clk);
      #1;
    end
    wb.req_valid = '0;
    @(negedge clk);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("drain_wr_en",   wb.rf_wr_en,   e.en);
      chk("drain_wr_addr", wb.rf_wr_addr, e.addr);
      chk("drain_wr_data", wb.rf_wr_data, e.data);
    end

    // Issue, hazard, WAW stall and commit-clear on x7
    do_reset();
    iss_valid = 1'b1;
    iss_addr  = 5'd7;
    rs1_addr  = 5'd7;
    rs2_addr  = 5'd3;
    @(negedge clk);
    chk("iss7_first_stall", iss_stall, 0);
    @(posedge clk);
    #1 iss_valid = 1'b0;
    @(negedge clk);
    chk("iss7_busy",  busy, SB_EN ? 32'h80 : 32'h0);
    chk("iss7_haz1",  hazard_rs1, SB_EN);
    chk("iss7_haz2",  hazard_rs2, 0);
    @(posedge clk);
    #1 iss_valid = 1'b1;
    @(negedge clk);
    chk("iss7_waw_stall", iss_stall, SB_EN);
    @(posedge clk);
    #1 iss_valid = 1'b0;
    @(negedge clk);
    chk("iss7_stall_nochange", busy, SB_EN ? 32'h80 : 32'h0);
    @(posedge clk);
    #1;
    wb.req_valid = 3'b001;
    wb.req_addr  = {5'd0, 5'd0, 5'd7};
    wb.req_data  = {32'h0, 32'h0, 32'h77};
    @(negedge clk);
    chk("wb7_ready", wb.req_ready, 3'b001);
    @(posedge clk);
    #1 wb.req_valid = '0;
    @(negedge clk);
    chk("wb7_wr_en",   wb.rf_wr_en, 1);
    chk("wb7_wr_addr", wb.rf_wr_addr, 7);
    chk("wb7_busy_before_commit", busy, SB_EN ? 32'h80 : 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("wb7_busy_cleared", busy, 0);
    chk("wb7_haz1_cleared", hazard_rs1, 0);
    chk("wb7_wr_en_low",    wb.rf_wr_en, 0);

    // Issue and commit of x9 on the same edge: set wins
    do_reset();
    wb.req_valid = 3'b001;
    wb.req_addr  = {5'd0, 5'd0, 5'd9};
    wb.req_data  = {32'h0, 32'h0, 32'h99};
    @(posedge clk);
    #1;
    wb.req_valid = '0;
    iss_valid    = 1'b1;
    iss_addr     = 5'd9;
    @(negedge clk);
    chk("x9_commit_en", wb.rf_wr_en, 1);
    chk("x9_iss_stall", iss_stall, 0);
    @(posedge clk);
    #1 iss_valid = 1'b0;
    @(negedge clk);
    chk("x9_set_wins", busy, SB_EN ? 32'h200 : 32'h0);

    // Asynchronous reset with a write pending and x7 busy
    do_reset();
    iss_valid    = 1'b1;
    iss_addr     = 5'd7;
    rs1_addr     = 5'd7;
    wb.req_valid = 3'b001;
    wb.req_addr  = {5'd0, 5'd0, 5'd3};
    wb.req_data  = {32'h0, 32'h0, 32'h55};
    @(posedge clk);
    #1;
    iss_valid    = 1'b0;
    wb.req_valid = '0;
    @(negedge clk);
    chk("rst_pre_wr_en", wb.rf_wr_en, 1);
    chk("rst_pre_busy",  busy, SB_EN ? 32'h80 : 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_wr_en",   wb.rf_wr_en, 0);
    chk("rst_async_wr_addr", wb.rf_wr_addr, 0);
    chk("rst_async_wr_data", wb.rf_wr_data, 0);
    chk("rst_async_busy",    busy, 0);
    chk("rst_async_haz1",    hazard_rs1, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_no_write", wb.rf_wr_en, 0);
    chk("rst_busy_after", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
